// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage that sits right after execute. It takes the ALU result
// as the effective address and rs2 as store data. It runs one request/ack
// transaction with data memory and stalls the core until that transaction
// completes. When it finishes it presents the extended load data for
// write-back.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid           memory instruction present (held while stall=1)
//   mem_write           1 = store, 0 = load
//   funct3              RV32I width/sign code (B, H, W, BU, HU)
//   addr, wdata         effective address, store data
//   stall               freeze PC and upstream stages
//   result_valid        one-cycle completion pulse
//   rdata_out           extended load data (0 for stores/faults/timeouts)
//   fault               misaligned address or illegal funct3
//   bus_err             access abandoned after TIMEOUT_CYCLES without ack
//   dmem_req/we/addr/be/wdata   memory request side (word-aligned address)
//   dmem_ack, dmem_rdata        memory response side
//
// Build option
//   LSU_TIMEOUT_EN      when defined, an 8-bit BUSY-cycle counter abandons
//                       an access after TIMEOUT_CYCLES cycles without ack.
//                       When undefined, BUSY waits indefinitely and bus_err
//                       is tied to 0.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  fault,
    output logic                  bus_err,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must fit the 8-bit BUSY counter (1..255)");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_fault;

    logic                  w_busy;
    logic                  w_in_bad;
    logic                  w_timeout;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wlane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_ext;

    // Decode of the incoming request: funct3 011/110/111 is illegal; halfword
    // must be 2-byte aligned and word 4-byte aligned.
    always_comb begin
        w_in_bad = 1'b0;
        if (funct3 inside {3'b011, 3'b110, 3'b111}) begin
            w_in_bad = 1'b1;
        end else if (funct3[1:0] == 2'b01 && addr[0]) begin
            w_in_bad = 1'b1;
        end else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
            w_in_bad = 1'b1;
        end
    end

    // Byte enables and store lanes come from the latched request only.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension.
    assign w_byte = dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = dmem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = dmem_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: ;
        endcase
    end

    // Next-state and FSM outputs
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        result_valid = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    w_state_next = w_in_bad ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall  = 1'b1;
                w_busy = 1'b1;
                // Ack takes priority over a timeout on the same cycle.
                if (dmem_ack || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign dmem_req   = w_busy;
    assign dmem_we    = w_busy & r_we;
    assign dmem_addr  = w_busy ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_be    = w_busy ? w_be : 4'b0000;
    assign dmem_wdata = w_busy ? w_wlane : '0;
    assign rdata_out  = r_rdata;
    assign fault      = r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && req_valid) begin
                r_we     <= mem_write;
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_rdata  <= '0;
                r_fault  <= w_in_bad;
            end else if (r_state == BUSY && dmem_ack && !r_we) begin
                r_rdata <= w_load_ext;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_bus_err;

    // r_cnt counts completed BUSY cycles without ack; the cycle on which it
    // reads TIMEOUT_LAST is the TIMEOUT_CYCLES-th BUSY cycle.
    assign w_timeout = w_busy && !dmem_ack && (r_cnt == TIMEOUT_LAST);
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= 8'd0;
                if (req_valid) begin
                    r_bus_err <= 1'b0;
                end
            end else if (w_busy && !dmem_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, result_valid, fault, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] rdata_out, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] word;
    } req_t;

    typedef struct {
        logic        fault;
        logic        bus_err;
        logic [31:0] rdata;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    bit   force_ack = 1'b0;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .result_valid(result_valid), .rdata_out(rdata_out), .fault(fault),
        .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, natural alignment, lane shift.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] word, output logic flt,
                                  output logic [3:0] be, output logic [31:0] wlane,
                                  output logic [31:0] rd);
        int     size;
        int     off;
        longint v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        flt   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((off % size) != 0);
        be    = 4'(((1 << size) - 1) << off);
        if (size == 1)      wlane = (wd & 32'hFF) * 32'h01010101;
        else if (size == 2) wlane = (wd & 32'hFFFF) * 32'h00010001;
        else                wlane = wd;
        v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        rd = (flt || we) ? 32'd0 : 32'(v);
    endfunction

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] word,
                             input int delay, input bit expect_timeout);
        logic        flt;
        logic [3:0]  be;
        logic [31:0] wlane, rd;
        int          n;
        int          exp_lat;
        res_t        r;
        model(we, f3, a, wd, word, flt, be, wlane, rd);
        if (!flt) req_q.push_back('{a & ~32'h3, be, we, wlane, delay, word});
        r.fault   = flt;
        r.bus_err = expect_timeout;
        r.rdata   = expect_timeout ? 32'd0 : rd;
        res_q.push_back(r);
        exp_lat = flt ? 1 : (expect_timeout ? 17 : delay + 2);
        @(negedge clk);
        req_valid = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        #1 check("stall_on_req", 32'(stall), 32'd1);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                addr = $urandom; wdata = $urandom;
                funct3 = 3'($urandom); mem_write = 1'($urandom);
            end
            if (result_valid) break;
            check("stall_busy", 32'(stall), 32'd1);
        end
        req_valid = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
        if (expect_timeout) req_q.delete();
        $display("txn we=%0d f3=%0d addr=%h wdata=%h word=%h delay=%0d lat=%0d",
                 we, f3, a, wd, word, delay, n);
    endtask

    // Memory responder: acks after the per-request delay, checks request fields.
    initial begin
        int   wc;
        req_t cur;
        wc = 0;
        forever begin
            @(negedge clk);
            dmem_ack = force_ack;
            if (!dmem_req) begin
                wc = 0;
            end else if (req_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_dmem_req: got dmem_req=1 expected 0 (addr %h)", dmem_addr);
            end else if (wc == req_q[0].delay) begin
                cur = req_q.pop_front();
                check("dmem_addr", dmem_addr, cur.addr);
                check("dmem_be", 32'(dmem_be), 32'(cur.be));
                check("dmem_we", 32'(dmem_we), 32'(cur.we));
                if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
                dmem_ack   = 1'b1;
                dmem_rdata = cur.word;
                wc = 0;
            end else begin
                wc++;
            end
        end
    end

    // Result monitor: pops the scoreboard on every result_valid.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got result_valid=1 expected 0");
                end else begin
                    r = res_q.pop_front();
                    check("fault", 32'(fault), 32'(r.fault));
                    check("bus_err", 32'(bus_err), 32'(r.bus_err));
                    check("rdata_out", rdata_out, r.rdata);
                    check("stall_done", 32'(stall), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", 32'({stall, result_valid, fault, bus_err, dmem_req, dmem_we, dmem_be}), 32'd0);
            check("idle_data", rdata_out | dmem_addr | dmem_wdata, 32'd0);
        end

        // Directed accesses
        do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b0);
        do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, 1'b0);
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 1, 1'b0);

        // Reset in the middle of BUSY; a late ack must be ignored.
        req_q.push_back('{32'h200, 4'hF, 1'b0, 32'h0, 1000, 32'h0});
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
        repeat (2) @(negedge clk);
        check("busy_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        req_q.delete();
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("late_ack", 32'({result_valid, dmem_req, stall}), 32'd0);
        end
        force_ack = 1'b0;
        $display("txn reset-during-busy done");
        do_access(1'b1, 3'b000, 32'h5, 32'hAB, 32'h0, 1, 1'b0);

`ifdef LSU_TIMEOUT_EN
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1000, 1'b1);
        do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 15, 1'b0);
`endif

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_access(we, f3, a, $urandom, $urandom, int'($urandom_range(0, 4)), 1'b0);
        end

        repeat (3) @(negedge clk);
        if (res_q.size() != 0 || req_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0",
                     res_q.size(), req_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the ALU result as the effective address and the second register-file read as store data, then runs a multi-cycle request/acknowledge transaction with data memory.
- Handles byte, halfword and word access: byte-enable generation, store-data lane replication, load sign/zero extension.
- Stalls the core until the access completes, then presents the load result for register write-back.

Parameters:
- DATA_WIDTH, 32, data/address width (only 32 supported).
- TIMEOUT_CYCLES, 16, BUSY cycles without ack before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  memory instruction present (MemRead or MemWrite); held by core while stall=1.
- mem_write  input  1  1=store, 0=load.
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  DATA_WIDTH  effective address (ALU output).
- wdata  input  DATA_WIDTH  store data (rs2 value).
- stall  output  1  freeze PC and upstream stages.
- result_valid  output  1  one-cycle pulse, access complete.
- rdata_out  output  DATA_WIDTH  extended load data; valid with result_valid on loads.
- fault  output  1  with result_valid: misaligned address or illegal funct3.
- bus_err  output  1  with result_valid: timeout abort.
- dmem_req  output  1  memory request.
- dmem_we  output  1  memory write enable.
- dmem_addr  output  DATA_WIDTH  word-aligned address; addr with [1:0] forced to 0.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  DATA_WIDTH  lane-replicated store data.
- dmem_ack  input  1  memory done; valid only while dmem_req=1.
- dmem_rdata  input  DATA_WIDTH  read word, valid with dmem_ack on reads.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_n=0 at clk edge):
  - state goes to IDLE.
  - stall, result_valid, fault, bus_err, dmem_req and dmem_we are all 0.
  - rdata_out, dmem_addr, dmem_be and dmem_wdata are all 0.
  - Applies mid-transaction: dmem_req drops on that same edge and any later ack is ignored.
- IDLE:
  - stall = req_valid (combinational).
  - When req_valid=1, latch mem_write, funct3, addr and wdata at the edge.
  - Legal access: go to BUSY.
  - Misaligned or illegal access: go to DONE with fault=1. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal means funct3 in {011,110,111}.
- BUSY:
  - dmem_req=1, dmem_we=latched mem_write; stall=1.
  - Outputs come from latched values only; input changes are ignored.
  - dmem_ack=1: capture the extended load data into rdata_out, go to DONE.
  - No ack: remain in BUSY.
- DONE:
  - result_valid=1, stall=0, dmem_req=0; go to IDLE next edge.
  - rdata_out, fault and bus_err hold until the next accept.
  - A req_valid present in DONE is not accepted; it is taken in the following IDLE cycle.
- Latency: accept edge, then at least 1 BUSY cycle, then DONE. The minimum is 3 cycles from req_valid to result_valid, ack-limited beyond that. A faulting access has 2-cycle latency.
- Byte enables, by access size:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
  - Loads drive the same dmem_be.
- Store data lanes:
  - B: wdata[7:0] replicated ×4.
  - H: wdata[15:0] replicated ×2.
  - W: unchanged.
- Load extraction: select the byte/half lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Stores leave rdata_out at 0 and never raise fault for data content.
- A faulting access never asserts dmem_req. rdata_out is 0 on fault.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - At TIMEOUT_CYCLES, the access is abandoned: go to DONE with bus_err=1, rdata_out=0, dmem_req dropped.
  - Ack on the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied to 0.

Test Plan:
- Reset then idle, req_valid=0 -> all outputs 0, stall=0, no dmem_req for 10 cycles.
- SW addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1. stall held 4 cycles, then result_valid for 1 cycle with fault=0.
- LB addr=0x103, dmem_rdata=0x80FF_1234, immediate ack -> be=1000, rdata_out=0xFFFFFF80. The same access as LBU gives 0x00000080.
- LH addr=0x102 with rdata 0x8001_0000 -> 0xFFFF8001. LW addr=0x102 -> no dmem_req, result_valid 2 cycles after accept, fault=1, rdata_out=0.
- Reset asserted during BUSY, then ack arrives -> dmem_req=0 after that edge, no result_valid, IDLE; the next SB addr=0x5, wdata=0xAB gives be=0010, dmem_wdata=0xABABABAB.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never returns -> result_valid with bus_err=1 exactly 16 BUSY cycles after entry. A separate run with ack on the 16th cycle -> bus_err=0 and data captured.
